// File: rtl/compositor_pkg.sv
// Shared types and constants for the layer compositor: colour and rectangle
// structs, the fixed 16-entry palette and the rectangle span test.
package compositor_pkg;

    localparam int COORD_W   = 10;
    localparam int IDX_W     = 4;
    localparam int PAL_DEPTH = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } rect_t;

    typedef rgb_t palette_t [PAL_DEPTH];

    // Palette index 0 never reaches the screen; the layer below shows through.
    localparam logic [IDX_W-1:0] TRANSPARENT_IDX = 4'd0;

    localparam palette_t PALETTE = '{
        '{8'h00, 8'h00, 8'h00},   // 0: transparent, never displayed
        '{8'hFF, 8'h00, 8'h00},
        '{8'h00, 8'hFF, 8'h00},
        '{8'h00, 8'h00, 8'hFF},
        '{8'hFF, 8'hFF, 8'h00},
        '{8'hFF, 8'h00, 8'hFF},
        '{8'h00, 8'hFF, 8'hFF},
        '{8'hFF, 8'hFF, 8'hFF},
        '{8'h80, 8'h00, 8'h00},
        '{8'h00, 8'h80, 8'h00},
        '{8'h00, 8'h00, 8'h80},
        '{8'h80, 8'h80, 8'h00},
        '{8'h80, 8'h00, 8'h80},
        '{8'h00, 8'h80, 8'h80},
        '{8'h80, 8'h80, 8'h80},
        '{8'hC0, 8'hC0, 8'hC0}
    };

    // True when pos lies in [start, start+len). The end is formed in 11 bits
    // so a span running past 1023 is clipped instead of wrapping to 0.
    function automatic logic in_span(
        input logic [COORD_W-1:0] pos,
        input logic [COORD_W-1:0] start,
        input logic [COORD_W-1:0] len
    );
        logic [COORD_W:0] limit_s;
        limit_s = {1'b0, start} + {1'b0, len};
        return (pos >= start) && ({1'b0, pos} < limit_s);
    endfunction

endpackage

// File: rtl/layer_hit_addr.sv
// Stage 0 for one sprite layer: registers whether the current pixel falls in
// the layer rectangle and the matching sprite ROM address.
module layer_hit_addr
    import compositor_pkg::*;
#(
    parameter int ADDR_W = 19
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [COORD_W-1:0]  draw_x,
    input  logic [COORD_W-1:0]  draw_y,
    input  logic                pix_valid,
    input  logic                en,
    input  logic                hide,
    input  rect_t               rect,
    output logic                hit,
    output logic [ADDR_W-1:0]   addr
);

    localparam int PROD_W = 2 * COORD_W + 1;

    logic                hit_s;
    logic [COORD_W-1:0]  off_x_s;
    logic [COORD_W-1:0]  off_y_s;
    logic [PROD_W-1:0]   prod_s;
    logic [ADDR_W-1:0]   addr_s;

    // Hit test and row-major address; the address is forced to 0 on a miss.
    always_comb begin
        hit_s   = en & pix_valid & ~hide
                & in_span(draw_x, rect.x, rect.w)
                & in_span(draw_y, rect.y, rect.h);
        off_x_s = draw_x - rect.x;
        off_y_s = draw_y - rect.y;
        prod_s  = PROD_W'(off_y_s) * PROD_W'(rect.w) + PROD_W'(off_x_s);
        if (hit_s) begin
            addr_s = ADDR_W'(prod_s);
        end else begin
            addr_s = '0;
        end
    end

    // Stage-0 register for the hit flag and ROM address.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit  <= 1'b0;
            addr <= '0;
        end else begin
            hit  <= hit_s;
            addr <= addr_s;
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Multi-layer sprite compositor: per-layer rectangle hit and ROM address at
// stage 0, hit/valid delay matching the ROM latency, then a priority pick of
// the first opaque layer, palette lookup and background fallback.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int ADDR_W     = 19,
    parameter int ROM_LAT    = 2,
    parameter int BLINK_BIT  = 4
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic [COORD_W-1:0]                   DrawX,
    input  logic [COORD_W-1:0]                   DrawY,
    input  logic                                 pix_valid,
    input  logic                                 frame_start,
    input  logic [NUM_LAYERS-1:0]                layer_en,
    input  logic [NUM_LAYERS-1:0]                layer_blink,
    input  logic [NUM_LAYERS-1:0][COORD_W-1:0]   layer_x,
    input  logic [NUM_LAYERS-1:0][COORD_W-1:0]   layer_y,
    input  logic [NUM_LAYERS-1:0][COORD_W-1:0]   layer_w,
    input  logic [NUM_LAYERS-1:0][COORD_W-1:0]   layer_h,
    output logic [NUM_LAYERS-1:0][ADDR_W-1:0]    sprite_addr,
    input  logic [NUM_LAYERS-1:0][IDX_W-1:0]     sprite_in,
    input  logic [23:0]                          bg_color,
    output logic [7:0]                           VGA_R,
    output logic [7:0]                           VGA_G,
    output logic [7:0]                           VGA_B,
    output logic                                 out_valid
);

    logic [7:0]              frame_cnt_r;
    logic                    blink_phase_s;
    logic [NUM_LAYERS-1:0]   hit0_s;
    logic [NUM_LAYERS-1:0]   hit_pipe_r   [1:ROM_LAT];
    logic                    valid_pipe_r [0:ROM_LAT];
    logic [NUM_LAYERS-1:0]   hit_al_s;
    logic                    valid_al_s;
    logic                    sel_found_s;
    logic [IDX_W-1:0]        sel_idx_s;
    rgb_t                    color_s;

    // Frame counter, advanced by each frame_start pulse and wrapping at 256.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt_r <= 8'd0;
        end else if (frame_start) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // The counter value before this cycle's increment sets the blink phase,
    // so a frame_start only affects pixels sampled after it.
    assign blink_phase_s = frame_cnt_r[BLINK_BIT];

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        rect_t rect_s;
        logic  hide_s;

        assign rect_s = '{x: layer_x[g], y: layer_y[g], w: layer_w[g], h: layer_h[g]};
        assign hide_s = layer_blink[g] & blink_phase_s;

        layer_hit_addr #(
            .ADDR_W (ADDR_W)
        ) u_hit_addr (
            .clk       (Clk),
            .reset     (Reset),
            .draw_x    (DrawX),
            .draw_y    (DrawY),
            .pix_valid (pix_valid),
            .en        (layer_en[g]),
            .hide      (hide_s),
            .rect      (rect_s),
            .hit       (hit0_s[g]),
            .addr      (sprite_addr[g])
        );
    end

    // Delay hit flags and pix_valid so they line up with the ROM data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k <= ROM_LAT; k++) begin
                valid_pipe_r[k] <= 1'b0;
            end
            for (int k = 1; k <= ROM_LAT; k++) begin
                hit_pipe_r[k] <= '0;
            end
        end else begin
            valid_pipe_r[0] <= pix_valid;
            hit_pipe_r[1]   <= hit0_s;
            for (int k = 1; k <= ROM_LAT; k++) begin
                valid_pipe_r[k] <= valid_pipe_r[k-1];
            end
            for (int k = 2; k <= ROM_LAT; k++) begin
                hit_pipe_r[k] <= hit_pipe_r[k-1];
            end
        end
    end

    assign hit_al_s   = hit_pipe_r[ROM_LAT];
    assign valid_al_s = valid_pipe_r[ROM_LAT];

    // Priority pick: scanning from the top layer down lets the
    // lowest-numbered opaque hit overwrite any higher-numbered one.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = TRANSPARENT_IDX;
        for (int l = NUM_LAYERS - 1; l >= 0; l--) begin
            if (hit_al_s[l] && (sprite_in[l] != TRANSPARENT_IDX)) begin
                sel_found_s = 1'b1;
                sel_idx_s   = sprite_in[l];
            end else begin
                sel_found_s = sel_found_s;
                sel_idx_s   = sel_idx_s;
            end
        end
    end

    // Colour select: blank outside the visible area, else sprite or background.
    always_comb begin
        if (!valid_al_s) begin
            color_s = '0;
        end else if (sel_found_s) begin
            color_s = PALETTE[sel_idx_s];
        end else begin
            color_s = rgb_t'(bg_color);
        end
    end

    // Output register for the composited colour and its valid flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            VGA_R     <= 8'd0;
            VGA_G     <= 8'd0;
            VGA_B     <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            VGA_R     <= color_s.r;
            VGA_G     <= color_s.g;
            VGA_B     <= color_s.b;
            out_valid <= valid_al_s;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: hand-derived vector table,
// blink and reset sequences, then randomized traffic against a pixel-level
// reference model with a latency queue.
module tb_layer_compositor;

    localparam int NL        = 4;
    localparam int ADDR_W    = 19;
    localparam int ROM_LAT   = 2;
    localparam int BLINK_BIT = 4;
    localparam int LAT       = ROM_LAT + 2;
    localparam logic [23:0] BG = 24'h123456;

    logic                      Clk = 1'b0;
    logic                      Reset;
    logic [9:0]                DrawX, DrawY;
    logic                      pix_valid, frame_start;
    logic [NL-1:0]             layer_en, layer_blink;
    logic [NL-1:0][9:0]        layer_x, layer_y, layer_w, layer_h;
    logic [NL-1:0][ADDR_W-1:0] sprite_addr;
    logic [NL-1:0][3:0]        sprite_in;
    logic [23:0]               bg_color;
    logic [7:0]                VGA_R, VGA_G, VGA_B;
    logic                      out_valid;

    layer_compositor #(
        .NUM_LAYERS (NL), .ADDR_W (ADDR_W), .ROM_LAT (ROM_LAT), .BLINK_BIT (BLINK_BIT)
    ) dut (
        .Clk (Clk), .Reset (Reset), .DrawX (DrawX), .DrawY (DrawY),
        .pix_valid (pix_valid), .frame_start (frame_start),
        .layer_en (layer_en), .layer_blink (layer_blink),
        .layer_x (layer_x), .layer_y (layer_y), .layer_w (layer_w), .layer_h (layer_h),
        .sprite_addr (sprite_addr), .sprite_in (sprite_in), .bg_color (bg_color),
        .VGA_R (VGA_R), .VGA_G (VGA_G), .VGA_B (VGA_B), .out_valid (out_valid)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- sprite ROM model ----------------
    logic       rom_fixed_mode;
    logic [3:0] rom_fixed [NL];
    logic [3:0] rom_pipe  [NL][ROM_LAT];

    function automatic logic [3:0] rom_val(input int l, input int a);
        int h;
        if (rom_fixed_mode) return rom_fixed[l];
        h = a * 13 + l * 7 + (a >> 5);
        if (h % 5 == 0) return 4'd0;
        return h[3:0];
    endfunction

    always @(posedge Clk) begin
        for (int l = 0; l < NL; l++) begin
            rom_pipe[l][0] <= rom_val(l, int'(sprite_addr[l]));
            for (int k = 1; k < ROM_LAT; k++) rom_pipe[l][k] <= rom_pipe[l][k-1];
        end
    end

    always_comb begin
        for (int l = 0; l < NL; l++) sprite_in[l] = rom_pipe[l][ROM_LAT-1];
    end

    // ---------------- reference model ----------------
    function automatic logic [23:0] pal(input logic [3:0] i);
        case (i)
            4'd1: return 24'hFF0000;   4'd2: return 24'h00FF00;
            4'd3: return 24'h0000FF;   4'd4: return 24'hFFFF00;
            4'd5: return 24'hFF00FF;   4'd6: return 24'h00FFFF;
            4'd7: return 24'hFFFFFF;   4'd8: return 24'h800000;
            4'd9: return 24'h008000;   4'd10: return 24'h000080;
            4'd11: return 24'h808000;  4'd12: return 24'h800080;
            4'd13: return 24'h008080;  4'd14: return 24'h808080;
            4'd15: return 24'hC0C0C0;
            default: return 24'h000000;
        endcase
    endfunction

    typedef struct packed { logic [23:0] rgb; logic v; } exp_t;
    exp_t exp_q [$];
    int   cnt;

    function automatic logic model_hit(input int l);
        int dx, dy, x, y, w, h;
        dx = DrawX; dy = DrawY;
        x = layer_x[l]; y = layer_y[l]; w = layer_w[l]; h = layer_h[l];
        if (!layer_en[l] || !pix_valid) return 1'b0;
        if (layer_blink[l] && (((cnt >> BLINK_BIT) & 1) != 0)) return 1'b0;
        return (dx >= x) && (dx < x + w) && (dy >= y) && (dy < y + h);
    endfunction

    // One clock: predict this pixel, advance, check address and due output.
    task automatic step();
        exp_t                      e, d;
        logic [NL-1:0][ADDR_W-1:0] ea;
        logic                      found;
        logic [3:0]                idx;
        e = '0; ea = '0; found = 1'b0;
        if (!Reset && pix_valid) begin
            e.v = 1'b1; e.rgb = bg_color;
            for (int l = 0; l < NL; l++) begin
                if (model_hit(l)) begin
                    ea[l] = ADDR_W'((int'(DrawY) - int'(layer_y[l])) * int'(layer_w[l])
                                    + (int'(DrawX) - int'(layer_x[l])));
                    idx = rom_val(l, int'(ea[l]));
                    if (!found && idx != 4'd0) begin
                        found = 1'b1; e.rgb = pal(idx);
                    end
                end
            end
        end
        exp_q.push_back(e);
        @(posedge Clk);
        if (Reset) begin
            cnt = 0;
            foreach (exp_q[i]) exp_q[i] = '0;
        end else if (frame_start) begin
            cnt = (cnt + 1) % 256;
        end
        #1;
        n_total++;
        if (sprite_addr !== ea) begin
            n_bad++;
            $display("FAIL addr got=%h want=%h t=%0t", sprite_addr, ea, $time);
        end
        if (exp_q.size() == LAT) begin
            d = exp_q.pop_front();
            n_total++;
            if ({VGA_R, VGA_G, VGA_B, out_valid} !== {d.rgb, d.v}) begin
                n_bad++;
                $display("FAIL pixel got=%h/%b want=%h/%b t=%0t",
                         {VGA_R, VGA_G, VGA_B}, out_valid, d.rgb, d.v, $time);
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic en0; logic [9:0] x0, y0, w0, h0;
        logic en1; logic [9:0] x1, y1, w1, h1;
        logic [3:0] i0, i1;
        logic [9:0] dx, dy; logic pv;
        logic [ADDR_W-1:0] ea0; logic [23:0] ergb; logic ev;
    } vec_t;

    function automatic vec_t mk(input int en0, x0, y0, w0, h0, en1, x1, y1, w1, h1,
                                input int i0, i1, dx, dy, pv, ea0, rgb, ev);
        vec_t v;
        v.en0 = 1'(en0); v.x0 = 10'(x0); v.y0 = 10'(y0); v.w0 = 10'(w0); v.h0 = 10'(h0);
        v.en1 = 1'(en1); v.x1 = 10'(x1); v.y1 = 10'(y1); v.w1 = 10'(w1); v.h1 = 10'(h1);
        v.i0 = 4'(i0); v.i1 = 4'(i1); v.dx = 10'(dx); v.dy = 10'(dy); v.pv = 1'(pv);
        v.ea0 = ADDR_W'(ea0); v.ergb = 24'(rgb); v.ev = 1'(ev);
        return v;
    endfunction

    task automatic idle(input int n);
        pix_valid = 1'b0; frame_start = 1'b0;
        repeat (n) step();
    endtask

    task automatic pulses(input int n);
        pix_valid = 1'b0;
        repeat (n) begin frame_start = 1'b1; step(); end
        frame_start = 1'b0;
    endtask

    // Present one pixel at (110,60), optionally with frame_start, check colour.
    task automatic px_check(input string nm, input logic fs, input logic [23:0] want);
        DrawX = 10'd110; DrawY = 10'd60; pix_valid = 1'b1; frame_start = fs;
        step();
        pix_valid = 1'b0; frame_start = 1'b0;
        repeat (LAT - 1) step();
        check(nm, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, want});
    endtask

    task automatic rand_layer(input int l);
        layer_en[l]    = ($urandom_range(0, 7) != 0);
        layer_blink[l] = ($urandom_range(0, 3) == 0);
        layer_x[l] = 10'(($urandom_range(0, 5) == 0) ? $urandom_range(900, 1023) : $urandom_range(0, 400));
        layer_y[l] = 10'(($urandom_range(0, 5) == 0) ? $urandom_range(900, 1023) : $urandom_range(0, 400));
        layer_w[l] = 10'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 300));
        layer_h[l] = 10'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 300));
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = mk(1,100,50,32,32, 0,0,0,0,0,      3,0, 131,81,1, 1023, 24'h0000FF,1);
        tbl[1]  = mk(1,100,50,32,32, 0,0,0,0,0,      3,0, 132,81,1, 0,    BG,1);
        tbl[2]  = mk(1,100,50,32,32, 0,0,0,0,0,      3,0, 100,82,1, 0,    BG,1);
        tbl[3]  = mk(1,100,50,32,32, 1,100,50,32,32, 0,5, 100,50,1, 0,    24'hFF00FF,1);
        tbl[4]  = mk(1,100,50,32,32, 1,100,50,32,32, 2,5, 101,51,1, 33,   24'h00FF00,1);
        tbl[5]  = mk(1,1000,0,40,10, 0,0,0,0,0,      3,0, 5,0,1,    0,    BG,1);
        tbl[6]  = mk(1,1000,0,40,10, 0,0,0,0,0,      3,0, 1010,3,1, 130,  24'h0000FF,1);
        tbl[7]  = mk(1,100,50,32,32, 0,0,0,0,0,      3,0, 131,81,0, 0,    24'h000000,0);
        tbl[8]  = mk(1,100,50,0,32,  0,0,0,0,0,      3,0, 100,50,1, 0,    BG,1);
        tbl[9]  = mk(1,100,50,32,0,  0,0,0,0,0,      3,0, 100,50,1, 0,    BG,1);
        tbl[10] = mk(0,100,50,32,32, 0,0,0,0,0,      3,0, 110,60,1, 0,    BG,1);
        tbl[11] = mk(0,100,50,32,32, 1,100,50,32,32, 3,7, 110,60,1, 0,    24'hFFFFFF,1);

        cnt = 0;
        Reset = 1'b1; DrawX = '0; DrawY = '0; pix_valid = 1'b0; frame_start = 1'b0;
        layer_en = '0; layer_blink = '0;
        layer_x = '0; layer_y = '0; layer_w = '0; layer_h = '0;
        bg_color = BG; rom_fixed_mode = 1'b1;
        for (int l = 0; l < NL; l++) rom_fixed[l] = 4'd0;
        repeat (3) step();
        check("reset_out", {7'h0, out_valid, VGA_R, VGA_G, VGA_B}, 32'h0);
        Reset = 1'b0;
        idle(LAT);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            layer_en = '0; layer_blink = '0;
            layer_en[0] = tbl[i].en0; layer_x[0] = tbl[i].x0; layer_y[0] = tbl[i].y0;
            layer_w[0] = tbl[i].w0;   layer_h[0] = tbl[i].h0;
            layer_en[1] = tbl[i].en1; layer_x[1] = tbl[i].x1; layer_y[1] = tbl[i].y1;
            layer_w[1] = tbl[i].w1;   layer_h[1] = tbl[i].h1;
            rom_fixed[0] = tbl[i].i0; rom_fixed[1] = tbl[i].i1;
            DrawX = tbl[i].dx; DrawY = tbl[i].dy; pix_valid = tbl[i].pv;
            step();
            check($sformatf("tbl%0d_addr", i), 32'(sprite_addr[0]), 32'(tbl[i].ea0));
            idle(LAT - 1);
            check($sformatf("tbl%0d_rgb", i), {7'h0, out_valid, VGA_R, VGA_G, VGA_B},
                  {7'h0, tbl[i].ev, tbl[i].ergb});
            idle(1);
        end

        // Blink sequence on layer 0 from a fresh counter.
        Reset = 1'b1; idle(1); Reset = 1'b0;
        layer_en = '0; layer_blink = '0;
        layer_en[0] = 1'b1; layer_blink[0] = 1'b1;
        layer_x[0] = 10'd100; layer_y[0] = 10'd50; layer_w[0] = 10'd32; layer_h[0] = 10'd32;
        rom_fixed[0] = 4'd3;
        pulses(15);
        px_check("blink_same_cycle", 1'b1, 24'h0000FF);
        px_check("blink_16", 1'b0, BG);
        pulses(16);
        px_check("blink_32", 1'b0, 24'h0000FF);
        pulses(224);
        px_check("blink_256", 1'b0, 24'h0000FF);
        pulses(16);
        px_check("blink_272", 1'b0, BG);

        // Reset pulsed mid-line in a continuous stream.
        layer_blink = '0;
        DrawY = 10'd60; pix_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin DrawX = 10'(100 + i); step(); end
        Reset = 1'b1; DrawX = 10'd108; step();
        check("rst_flush0", {31'h0, out_valid}, 32'h0);
        Reset = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            DrawX = 10'(109 + i); step();
            check("rst_flush", {7'h0, out_valid, VGA_R, VGA_G, VGA_B}, 32'h0);
        end
        DrawX = 10'd120; step();
        check("rst_resume", {7'h0, out_valid, VGA_R, VGA_G, VGA_B}, {8'h01, 24'h0000FF});
        idle(LAT);

        // Randomized traffic against the model.
        rom_fixed_mode = 1'b0;
        for (int l = 0; l < NL; l++) rand_layer(l);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) rand_layer($urandom_range(0, NL - 1));
            DrawX = 10'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 1023) : $urandom_range(0, 600));
            DrawY = 10'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 1023) : $urandom_range(0, 600));
            pix_valid   = ($urandom_range(0, 9) != 0);
            frame_start = ($urandom_range(0, 7) == 0);
            Reset       = ($urandom_range(0, 499) == 0);
            step();
        end
        Reset = 1'b0;
        idle(LAT + 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4: sprite layers composited; layer 0 has highest priority.
REQ-002 SHALL have parameter ADDR_W, default 19: sprite ROM address width.
REQ-003 SHALL have parameter ROM_LAT, default 2: sprite ROM read latency in cycles, legal range 1..4.
REQ-004 SHALL have parameter BLINK_BIT, default 4: frame-counter bit that selects blink phase, legal range 0..7.
REQ-005 Clk  in  1  the single clock; every register is clocked on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 DrawX, DrawY  in  10 each  coordinates of the current pixel.
REQ-008 pix_valid  in  1  the current pixel is in the visible area.
REQ-009 frame_start  in  1  single-cycle pulse at the start of each frame.
REQ-010 layer_en, layer_blink  in  NUM_LAYERS each  per-layer enable and per-layer blink mode.
REQ-011 layer_x, layer_y, layer_w, layer_h  in  NUM_LAYERS x 10 each  rectangle top-left corner and full width/height.
REQ-012 sprite_addr  out  NUM_LAYERS x ADDR_W  per-layer sprite ROM address.
REQ-013 sprite_in  in  NUM_LAYERS x 4  per-layer palette index returned by the ROM.
REQ-014 bg_color  in  24  background colour {R,G,B}.
REQ-015 VGA_R, VGA_G, VGA_B  out  8 each  composited colour.
REQ-016 out_valid  out  1  pix_valid delayed to align with the colour outputs.

Function
REQ-017 Stage 0 SHALL register, per layer, hit = layer_en & visible & in-rectangle, where X is in [layer_x, layer_x+layer_w) and Y is in [layer_y, layer_y+layer_h).
REQ-018 The rectangle sums SHALL be evaluated in 11 bits, so a rectangle extending past 1023 is clipped and never wraps to low coordinates.
REQ-019 A layer with layer_w=0 or layer_h=0 SHALL never hit.
REQ-020 Stage 0 SHALL register sprite_addr = (DrawY-layer_y)*layer_w + (DrawX-layer_x), truncated to ADDR_W, when the layer hits; otherwise sprite_addr SHALL be 0.
REQ-021 sprite_in for a given address SHALL be taken as valid exactly ROM_LAT cycles after that sprite_addr is registered; the hit flags and pix_valid SHALL be delayed by the same amount through a shift pipeline.
REQ-022 Palette index 0 SHALL be transparent. The final stage SHALL select the lowest-numbered layer that hits and has a non-zero index, look that index up in the 16-entry palette, and fall back to bg_color when no layer qualifies.
REQ-023 Total latency from DrawX/DrawY/pix_valid to VGA_*/out_valid SHALL be ROM_LAT+2 cycles, with throughput of one pixel per cycle and no stalls.
REQ-024 When the delayed pix_valid is 0, VGA_R, VGA_G and VGA_B SHALL output 0.
REQ-025 The 8-bit frame counter SHALL increment on each frame_start pulse and wrap from 255 to 0.
REQ-026 A layer with layer_blink=1 SHALL be treated as not hitting while counter bit BLINK_BIT is 1.
REQ-027 Blink phase SHALL be sampled at stage 0; a frame_start pulse on the same cycle affects only the following pixels, never pixels already in the pipeline.
REQ-028 All layer_* inputs SHALL be sampled every cycle with no shadowing; changing them mid-frame takes effect at the next stage-0 sample.

Reset
REQ-029 While Reset=1, VGA_R/G/B, out_valid, sprite_addr, all pipeline hit/valid bits and the frame counter SHALL be 0 on the next edge.
REQ-030 A reset asserted mid-frame SHALL flush the pipeline; out_valid SHALL remain 0 for ROM_LAT+2 cycles after Reset deasserts, unless pix_valid is high during that window.

Structure
REQ-031 Package compositor_pkg SHALL hold the rgb_t struct {r,g,b 8-bit}, the rect_t struct {x,y,w,h 10-bit}, the 16-entry PALETTE constant of rgb_t (index 0 unused), and the TRANSPARENT_IDX constant set to 0.
REQ-032 One sub-module, layer_hit_addr (stage-0 hit and address for one layer), SHALL be instantiated NUM_LAYERS times via generate.

Verification
REQ-033 Single layer at (100,50), 32x32, ROM returns index 3: DrawX=131, DrawY=81 -> sprite_addr=1023 one cycle later; PALETTE[3] appears ROM_LAT+2 cycles later. DrawX=132 -> bg_color.
REQ-034 Layers 0 and 1 overlap: layer 0 index 0 and layer 1 index 5 -> PALETTE[5]; then layer 0 index 2 -> PALETTE[2].
REQ-035 layer_x=1000, layer_w=40, DrawX=5 -> no hit, sprite_addr=0 (no wrap).
REQ-036 layer_blink=1, BLINK_BIT=4: after 16 frame_start pulses the layer is hidden; after 32 pulses it is visible; after 256 pulses the counter reads 0.
REQ-037 Continuous pixel stream with Reset pulsed for one cycle mid-line: out_valid=0 and colours 0 until the first post-reset pixel emerges ROM_LAT+2 cycles later.
REQ-038 pix_valid=0 while inside a hitting rectangle: VGA_*=0 and out_valid=0 at output latency.
